id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RISC-V pipeline. It latches decoded instruction fields from ID into EX each cycle. It inserts a single-cycle bubble and stalls IF/ID when an EX-stage load feeds an ID-stage source register, and squashes the ID instruction on a taken branch or jump. Its `Rd_EX` and `RegWEN_EX` outputs feed the forwarding control directly. It also keeps a saturating count of inserted bubbles for performance monitoring.

---
 rtl/id_ex_stage.sv | 143 ++++++++++++++
 tb/tb_id_ex_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
// Load-use hazard detection, branch squash and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Valid_ID,
    input  logic [XLEN-1:0]  PC_ID,
    input  logic [4:0]       Rs1_ID,
    input  logic [4:0]       Rs2_ID,
    input  logic [4:0]       Rd_ID,
    input  logic             Rs1Used_ID,
    input  logic             Rs2Used_ID,
    input  logic [XLEN-1:0]  Data1_ID,
    input  logic [XLEN-1:0]  Data2_ID,
    input  logic [XLEN-1:0]  Imm_ID,
    input  logic [3:0]       ALUSel_ID,
    input  logic             RegWEN_ID,
    input  logic             MemRead_ID,
    input  logic             MemWrite_ID,
    input  logic             Flush_EX,
    output logic             Valid_EX,
    output logic [XLEN-1:0]  PC_EX,
    output logic [4:0]       Rs1_EX,
    output logic [4:0]       Rs2_EX,
    output logic [4:0]       Rd_EX,
    output logic [XLEN-1:0]  Data1_EX,
    output logic [XLEN-1:0]  Data2_EX,
    output logic [XLEN-1:0]  Imm_EX,
    output logic [3:0]       ALUSel_EX,
    output logic             RegWEN_EX,
    output logic             MemRead_EX,
    output logic             MemWrite_EX,
    output logic             Stall_IF_ID,
    output logic [CNT_W-1:0] Bubble_Cnt
);

    logic             valid_q,    valid_d;
    logic [XLEN-1:0]  pc_q,       pc_d;
    logic [4:0]       rs1_q,      rs1_d;
    logic [4:0]       rs2_q,      rs2_d;
    logic [4:0]       rd_q,       rd_d;
    logic [XLEN-1:0]  data1_q,    data1_d;
    logic [XLEN-1:0]  data2_q,    data2_d;
    logic [XLEN-1:0]  imm_q,      imm_d;
    logic [3:0]       alusel_q,   alusel_d;
    logic             regwen_q,   regwen_d;
    logic             memread_q,  memread_d;
    logic             memwrite_q, memwrite_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic hazard;
    logic bubble;

    // The bubble clears MemRead_EX, so a load-use stall self-terminates after one cycle.
    always_comb begin
        hazard = Valid_ID & memread_q & regwen_q & (rd_q != 5'd0) &
                 ((Rs1Used_ID & (Rs1_ID == rd_q)) | (Rs2Used_ID & (Rs2_ID == rd_q)));
        bubble      = Flush_EX | hazard;
        Stall_IF_ID = hazard & ~Flush_EX;
    end

    always_comb begin
        valid_d    = Valid_ID;
        pc_d       = PC_ID;
        rs1_d      = Rs1_ID;
        rs2_d      = Rs2_ID;
        rd_d       = Rd_ID;
        data1_d    = Data1_ID;
        data2_d    = Data2_ID;
        imm_d      = Imm_ID;
        alusel_d   = ALUSel_ID;
        regwen_d   = RegWEN_ID;
        memread_d  = MemRead_ID;
        memwrite_d = MemWrite_ID;
        bubble_cnt_d = bubble_cnt_q;
        if (bubble) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            data1_d    = '0;
            data2_d    = '0;
            imm_d      = '0;
            alusel_d   = '0;
            regwen_d   = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            if (bubble_cnt_q != '1)
                bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            imm_q        <= '0;
            alusel_q     <= '0;
            regwen_q     <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            imm_q        <= imm_d;
            alusel_q     <= alusel_d;
            regwen_q     <= regwen_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign Valid_EX    = valid_q;
    assign PC_EX       = pc_q;
    assign Rs1_EX      = rs1_q;
    assign Rs2_EX      = rs2_q;
    assign Rd_EX       = rd_q;
    assign Data1_EX    = data1_q;
    assign Data2_EX    = data2_q;
    assign Imm_EX      = imm_q;
    assign ALUSel_EX   = alusel_q;
    assign RegWEN_EX   = regwen_q;
    assign MemRead_EX  = memread_q;
    assign MemWrite_EX = memwrite_q;
    assign Bubble_Cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: behavioural EX-state model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk, rst_n;
    logic             Valid_ID;
    logic [XLEN-1:0]  PC_ID;
    logic [4:0]       Rs1_ID, Rs2_ID, Rd_ID;
    logic             Rs1Used_ID, Rs2Used_ID;
    logic [XLEN-1:0]  Data1_ID, Data2_ID, Imm_ID;
    logic [3:0]       ALUSel_ID;
    logic             RegWEN_ID, MemRead_ID, MemWrite_ID, Flush_EX;
    logic             Valid_EX;
    logic [XLEN-1:0]  PC_EX;
    logic [4:0]       Rs1_EX, Rs2_EX, Rd_EX;
    logic [XLEN-1:0]  Data1_EX, Data2_EX, Imm_EX;
    logic [3:0]       ALUSel_EX;
    logic             RegWEN_EX, MemRead_EX, MemWrite_EX, Stall_IF_ID;
    logic [CNT_W-1:0] Bubble_Cnt;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .Valid_ID(Valid_ID), .PC_ID(PC_ID),
        .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID), .Rd_ID(Rd_ID),
        .Rs1Used_ID(Rs1Used_ID), .Rs2Used_ID(Rs2Used_ID),
        .Data1_ID(Data1_ID), .Data2_ID(Data2_ID), .Imm_ID(Imm_ID),
        .ALUSel_ID(ALUSel_ID), .RegWEN_ID(RegWEN_ID), .MemRead_ID(MemRead_ID),
        .MemWrite_ID(MemWrite_ID), .Flush_EX(Flush_EX),
        .Valid_EX(Valid_EX), .PC_EX(PC_EX), .Rs1_EX(Rs1_EX), .Rs2_EX(Rs2_EX),
        .Rd_EX(Rd_EX), .Data1_EX(Data1_EX), .Data2_EX(Data2_EX), .Imm_EX(Imm_EX),
        .ALUSel_EX(ALUSel_EX), .RegWEN_EX(RegWEN_EX), .MemRead_EX(MemRead_EX),
        .MemWrite_EX(MemWrite_EX), .Stall_IF_ID(Stall_IF_ID), .Bubble_Cnt(Bubble_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic            v;
        logic [XLEN-1:0] pc, d1, d2, imm;
        logic [4:0]      rs1, rs2, rd;
        logic [3:0]      alu;
        logic            we, mr, mw;
    } ex_t;

    ex_t m;
    int  mcnt;

    function automatic bit model_hazard();
        return Valid_ID && m.mr && m.we && (m.rd != 0) &&
               ((Rs1Used_ID && Rs1_ID == m.rd) || (Rs2Used_ID && Rs2_ID == m.rd));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m = '{default: 0};
            mcnt = 0;
        end else if (Flush_EX || model_hazard()) begin
            m = '{default: 0};
            if (mcnt < (1 << CNT_W) - 1) mcnt++;
        end else begin
            m.v = Valid_ID;  m.pc = PC_ID;   m.d1 = Data1_ID; m.d2 = Data2_ID;
            m.imm = Imm_ID;  m.rs1 = Rs1_ID; m.rs2 = Rs2_ID;  m.rd = Rd_ID;
            m.alu = ALUSel_ID; m.we = RegWEN_ID; m.mr = MemRead_ID; m.mw = MemWrite_ID;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_valid", Valid_EX, m.v);
            chk("m_pc", PC_EX, m.pc);
            chk("m_rs1", Rs1_EX, m.rs1);
            chk("m_rs2", Rs2_EX, m.rs2);
            chk("m_rd", Rd_EX, m.rd);
            chk("m_data1", Data1_EX, m.d1);
            chk("m_data2", Data2_EX, m.d2);
            chk("m_imm", Imm_EX, m.imm);
            chk("m_alusel", ALUSel_EX, m.alu);
            chk("m_regwen", RegWEN_EX, m.we);
            chk("m_memread", MemRead_EX, m.mr);
            chk("m_memwrite", MemWrite_EX, m.mw);
            chk("m_stall", Stall_IF_ID, model_hazard() && !Flush_EX);
            chk("m_cnt", Bubble_Cnt, mcnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Generic ALU op: no memory access, writes rd.
    task automatic op_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic [XLEN-1:0] pc);
        Valid_ID = 1'b1; PC_ID = pc; Rs1_ID = rs1; Rs2_ID = rs2; Rd_ID = rd;
        Rs1Used_ID = u1; Rs2Used_ID = u2;
        Data1_ID = pc ^ 32'hA5A5_0000; Data2_ID = pc + 32'h11; Imm_ID = pc >> 2;
        ALUSel_ID = pc[5:2]; RegWEN_ID = 1'b1; MemRead_ID = 1'b0; MemWrite_ID = 1'b0;
    endtask

    task automatic load_id(input logic [4:0] rd, input logic [XLEN-1:0] pc);
        op_id(5'd2, 1'b1, 5'd0, 1'b0, rd, pc);
        MemRead_ID = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; Flush_EX = 1'b0;
        op_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 32'h100);
        MemRead_ID = 1'b1;
        #1;
        cmp_en = 1'b1;
        repeat (3) tick();
        chk("rst_valid", Valid_EX, 0);
        chk("rst_pc", PC_EX, 0);
        chk("rst_rd", Rd_EX, 0);
        chk("rst_cnt", Bubble_Cnt, 0);
        chk("rst_stall", Stall_IF_ID, 0);

        @(negedge clk); #1; rst_n = 1'b1;
        MemRead_ID = 1'b0;
        tick();
        chk("post_rst_pc", PC_EX, 32'h100);
        chk("post_rst_rd", Rd_EX, 5);
        chk("post_rst_valid", Valid_EX, 1);

        // Load-use on rs1
        load_id(5'd3, 32'h104);
        tick();
        op_id(5'd3, 1'b1, 5'd9, 1'b1, 5'd10, 32'h108);
        #1;
        chk("lu_stall", Stall_IF_ID, 1);
        tick();
        chk("lu_bubble_valid", Valid_EX, 0);
        chk("lu_bubble_we", RegWEN_EX, 0);
        chk("lu_cnt", Bubble_Cnt, 1);
        chk("lu_stall_clear", Stall_IF_ID, 0);
        tick();
        chk("lu_add_rs1", Rs1_EX, 3);
        chk("lu_add_valid", Valid_EX, 1);

        // Load to x0: never stalls
        load_id(5'd0, 32'h10C);
        tick();
        op_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 32'h110);
        #1;
        chk("x0_stall", Stall_IF_ID, 0);
        tick();
        chk("x0_valid", Valid_EX, 1);

        // rs2 matches but is not read
        load_id(5'd4, 32'h114);
        tick();
        op_id(5'd1, 1'b1, 5'd4, 1'b0, 5'd12, 32'h118);
        #1;
        chk("unused_stall", Stall_IF_ID, 0);
        tick();
        chk("unused_valid", Valid_EX, 1);
        chk("unused_cnt", Bubble_Cnt, 1);

        // Invalid ID instruction never stalls
        load_id(5'd9, 32'h11C);
        tick();
        op_id(5'd9, 1'b1, 5'd9, 1'b1, 5'd13, 32'h120);
        Valid_ID = 1'b0;
        #1;
        chk("inv_stall", Stall_IF_ID, 0);
        tick();

        // Store consuming the load result via rs2
        load_id(5'd6, 32'h124);
        tick();
        op_id(5'd1, 1'b1, 5'd6, 1'b1, 5'd0, 32'h128);
        RegWEN_ID = 1'b0; MemWrite_ID = 1'b1;
        #1;
        chk("st_stall", Stall_IF_ID, 1);
        tick();
        chk("st_cnt", Bubble_Cnt, 2);
        tick();
        chk("st_memwrite", MemWrite_EX, 1);

        // Flush and hazard together: flush wins
        load_id(5'd7, 32'h12C);
        tick();
        op_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd14, 32'h130);
        Flush_EX = 1'b1;
        #1;
        chk("fl_stall", Stall_IF_ID, 0);
        tick();
        chk("fl_valid", Valid_EX, 0);
        chk("fl_cnt", Bubble_Cnt, 3);

        // Saturation: 20 consecutive flushes
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt", Bubble_Cnt, 15);
        tick();
        chk("sat_hold", Bubble_Cnt, 15);
        Flush_EX = 1'b0;

        // Reset during a stall
        load_id(5'd8, 32'h134);
        tick();
        op_id(5'd8, 1'b1, 5'd0, 1'b0, 5'd15, 32'h138);
        #1;
        chk("mrst_stall_pre", Stall_IF_ID, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_stall", Stall_IF_ID, 0);
        chk("mrst_valid", Valid_EX, 0);
        chk("mrst_rd", Rd_EX, 0);
        chk("mrst_memread", MemRead_EX, 0);
        chk("mrst_cnt", Bubble_Cnt, 0);
        @(negedge clk); #1; rst_n = 1'b1;
        tick();
        chk("mrst_after_pc", PC_EX, 32'h138);
        tick();
        @(negedge clk); #1;
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
